flag_event_queue: RTL and testbench

- Upstream feeder for the flag synchronizer, in the source (clkA) domain.
- Accumulates single-cycle event pulses that arrive while the synchronizer is busy, then replays them one at a time as request pulses. Each replayed pulse is issued only after the previous crossing's busy feedback has risen and fallen again.
- Keeps bursty events from being silently dropped. Reports the backlog and any saturation loss.

---
 rtl/flag_event_queue.sv | 119 +++++++++++
 tb/tb_flag_event_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_event_queue.sv
// flag_event_queue: source-domain event accumulator feeding the flag synchronizer.
// Counts incoming event pulses and replays them one at a time as request pulses,
// waiting for each crossing's busy handshake to rise and fall before the next.
module flag_event_queue #(
   parameter int CNT_BITS     = 4,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                evt_i,
   input  logic                busy_i,
   input  logic                flag_clr_i,
   output logic                req_o,
   output logic [CNT_BITS-1:0] pending_o,
   output logic                overflow_o,
   output logic                timeout_o
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   localparam logic [CNT_BITS-1:0] PEND_MAX    = '1;
   localparam logic [CNT_BITS-1:0] PEND_ONE    = CNT_BITS'(1);
   localparam logic [7:0]          TIMEOUT_LIM = 8'(BUSY_TIMEOUT);

   state_t     state;
   state_t     stateNext;
   logic [7:0] toCnt;
   logic [7:0] toCntNext;
   logic       reqNext;
   logic       tmoSet;
   logic       decEvt;
   logic       pendFull;
   logic       ovfSet;

   // The ISSUE cycle is the one that consumes a queued event.
   assign decEvt   = (state == ISSUE);
   assign pendFull = (pending_o == PEND_MAX);
   assign ovfSet   = evt_i && !decEvt && pendFull;

   // Next-state, request and timeout decisions for the replay handshake.
   always_comb begin
      stateNext = state;
      toCntNext = toCnt;
      reqNext   = 1'b0;
      tmoSet    = 1'b0;
      case (state)
         IDLE: begin
            // A busy left over from another crossing holds us here.
            if ((pending_o != '0) && !busy_i) begin
               stateNext = ISSUE;
               reqNext   = 1'b1;
            end
         end
         ISSUE: begin
            stateNext = WAIT_BUSY;
            toCntNext = '0;
         end
         WAIT_BUSY: begin
            if (busy_i) begin
               stateNext = WAIT_DONE;
            end else begin
               toCntNext = toCnt + 8'd1;
               // Lost request is treated as consumed; it is not re-issued.
               if (toCntNext == TIMEOUT_LIM) begin
                  tmoSet    = 1'b1;
                  stateNext = IDLE;
               end
            end
         end
         WAIT_DONE: begin
            if (!busy_i) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State, request pulse, pending counter and sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         toCnt      <= '0;
         req_o      <= 1'b0;
         pending_o  <= '0;
         overflow_o <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         state <= stateNext;
         toCnt <= toCntNext;
         req_o <= reqNext;

         if (evt_i && !decEvt && !pendFull) begin
            pending_o <= pending_o + PEND_ONE;
         end else if (!evt_i && decEvt) begin
            pending_o <= pending_o - PEND_ONE;
         end

         // Set takes priority over a same-cycle clear.
         if (ovfSet) begin
            overflow_o <= 1'b1;
         end else if (flag_clr_i) begin
            overflow_o <= 1'b0;
         end

         if (tmoSet) begin
            timeout_o <= 1'b1;
         end else if (flag_clr_i) begin
            timeout_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_flag_event_queue.sv
// tb_flag_event_queue: randomized and directed checks of flag_event_queue
// against a transaction-level reference model of the event queue.
module tb_flag_event_queue;

   localparam int CNT_BITS = 4;
   localparam int TO_LIM   = 15;
   localparam int MAXP     = (1 << CNT_BITS) - 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                evt_i;
   logic                busy_i;
   logic                flag_clr_i;
   logic                req_o;
   logic [CNT_BITS-1:0] pending_o;
   logic                overflow_o;
   logic                timeout_o;

   flag_event_queue #(
      .CNT_BITS     (CNT_BITS),
      .BUSY_TIMEOUT (TO_LIM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .evt_i      (evt_i),
      .busy_i     (busy_i),
      .flag_clr_i (flag_clr_i),
      .req_o      (req_o),
      .pending_o  (pending_o),
      .overflow_o (overflow_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int reqCount = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue count plus the progress of one outstanding request.
   int mPend;
   bit mReq;
   bit mInFlight;
   bit mBusySeen;
   int mWait;
   bit mOvf;
   bit mTmo;
   bit mE, mB, mC, setO, setT, nReq;
   int nPend;

   always @(posedge clk) begin
      if (rst) begin
         mPend = 0; mReq = 0; mInFlight = 0; mBusySeen = 0; mWait = 0;
         mOvf = 0; mTmo = 0;
      end else begin
         mE = evt_i; mB = busy_i; mC = flag_clr_i;
         setO = 0; setT = 0; nReq = 0;
         nPend = mPend;
         if (mE && !mReq) begin
            if (mPend == MAXP) setO = 1;
            else nPend = mPend + 1;
         end else if (!mE && mReq) begin
            nPend = mPend - 1;
         end
         if (mReq) begin
            mInFlight = 1; mBusySeen = 0; mWait = 0;
         end else if (mInFlight) begin
            if (!mBusySeen) begin
               if (mB) mBusySeen = 1;
               else begin
                  mWait++;
                  if (mWait == TO_LIM) begin
                     setT = 1;
                     mInFlight = 0;
                  end
               end
            end else if (!mB) begin
               mInFlight = 0;
            end
         end else begin
            nReq = (mPend != 0) && !mB;
         end
         mOvf = setO ? 1'b1 : (mC ? 1'b0 : mOvf);
         mTmo = setT ? 1'b1 : (mC ? 1'b0 : mTmo);
         mPend = nPend;
         mReq = nReq;
      end
      #1;
      check("req_o", int'(req_o), int'(mReq));
      check("pending_o", int'(pending_o), mPend);
      check("overflow_o", int'(overflow_o), int'(mOvf));
      check("timeout_o", int'(timeout_o), int'(mTmo));
      if (req_o === 1'b1) reqCount++;
   end

   // Synchronizer stand-in: 0 = answers every request, 1 = busy held high,
   // 2 = busy held low, 3 = random delays/lengths, dropped requests, foreign blips.
   int busyMode = 0;
   int autoDur = 6;
   int busyLeft = 0;
   int startDly = 0;
   int curDur = 6;

   task automatic tick(input bit e, input bit c);
      @(negedge clk);
      if (busyMode == 1 || busyMode == 2) begin
         busyLeft = 0;
         startDly = 0;
         busy_i = (busyMode == 1);
      end else begin
         if (startDly > 0) begin
            startDly--;
            if (startDly == 0) busyLeft = curDur;
         end
         busy_i = (busyLeft > 0);
         if (busyLeft > 0) busyLeft--;
         if (busyMode == 3 && !busy_i && startDly == 0 && $urandom_range(0, 24) == 0)
            busy_i = 1'b1;
         if (req_o === 1'b1) begin
            if (busyMode == 0) begin
               startDly = 1;
               curDur = autoDur;
            end else if ($urandom_range(0, 15) != 0) begin
               startDly = $urandom_range(1, 3);
               curDur = $urandom_range(1, 8);
            end
         end
      end
      evt_i = e;
      flag_clr_i = c;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   int r0;
   int rate;

   initial begin
      rst = 1'b1; evt_i = 1'b0; busy_i = 1'b0; flag_clr_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_req", int'(req_o), 0);
      check("reset_pending", int'(pending_o), 0);
      check("reset_flags", int'({overflow_o, timeout_o}), 0);

      // Single event: request lands two cycles after the event.
      tick(1, 0);
      tick(0, 0);
      check("single_pend_t1", int'(pending_o), 1);
      check("single_req_t1", int'(req_o), 0);
      tick(0, 0);
      check("single_req_t2", int'(req_o), 1);
      tick(0, 0);
      check("single_req_t3", int'(req_o), 0);
      check("single_pend_t3", int'(pending_o), 0);
      repeat (12) tick(0, 0);
      check("single_flags", int'({overflow_o, timeout_o}), 0);

      // Burst of five events.
      r0 = reqCount;
      repeat (5) tick(1, 0);
      repeat (60) tick(0, 0);
      check("burst_reqs", reqCount - r0, 5);
      check("burst_pend_end", int'(pending_o), 0);

      // Increment and decrement in the same (ISSUE) cycle.
      busyMode = 1;
      repeat (3) tick(1, 0);
      tick(0, 0);
      check("incdec_pend_pre", int'(pending_o), 3);
      busyMode = 0;
      tick(0, 0);
      tick(1, 0);
      check("incdec_issue", int'(req_o), 1);
      check("incdec_pend_issue", int'(pending_o), 3);
      tick(0, 0);
      check("incdec_hold", int'(pending_o), 3);
      repeat (50) tick(0, 0);
      check("incdec_drain", int'(pending_o), 0);

      // Saturation with busy held high.
      busyMode = 1;
      repeat (20) tick(1, 0);
      tick(0, 0);
      check("sat_pend", int'(pending_o), 15);
      check("sat_ovf", int'(overflow_o), 1);
      tick(0, 1);
      tick(0, 0);
      check("sat_ovf_clr", int'(overflow_o), 0);
      r0 = reqCount;
      busyMode = 0;
      repeat (200) tick(0, 0);
      check("sat_reqs", reqCount - r0, 15);
      check("sat_pend_end", int'(pending_o), 0);

      // Timeout with busy tied low.
      busyMode = 2;
      r0 = reqCount;
      tick(1, 0);
      for (int j = 1; j <= 18; j++) begin
         tick(0, 0);
         if (j == 2) check("tmo_req_t2", int'(req_o), 1);
         if (j == 17) check("tmo_flag_t17", int'(timeout_o), 0);
      end
      check("tmo_flag_t18", int'(timeout_o), 1);
      check("tmo_pend", int'(pending_o), 0);
      repeat (20) tick(0, 0);
      check("tmo_reqs", reqCount - r0, 1);
      tick(0, 1);
      tick(0, 0);
      check("tmo_clr", int'(timeout_o), 0);

      // Reset during WAIT_DONE with a backlog of seven.
      busyMode = 0;
      autoDur = 40;
      repeat (8) tick(1, 0);
      repeat (2) tick(0, 0);
      check("rstmid_pend_pre", int'(pending_o), 7);
      #1 rst = 1'b1;
      #1;
      check("rstmid_req", int'(req_o), 0);
      check("rstmid_pend", int'(pending_o), 0);
      check("rstmid_flags", int'({overflow_o, timeout_o}), 0);
      busyMode = 2;
      autoDur = 6;
      tick(0, 0);
      tick(0, 0);
      rst = 1'b0;
      r0 = reqCount;
      repeat (10) tick(0, 0);
      check("rstmid_no_req", reqCount - r0, 0);
      check("rstmid_pend_after", int'(pending_o), 0);

      // Randomized traffic with varying density.
      busyMode = 3;
      rate = 30;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) rate = $urandom_range(5, 90);
         tick($urandom_range(0, 99) < rate, $urandom_range(0, 39) == 0);
      end
      busyMode = 0;
      repeat (300) tick(0, 0);
      check("random_drain", int'(pending_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
